// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised Moore pattern detector: state width and
// the elaboration-time KMP next-state function that fills its transition table.
package seq_det_pkg;

  localparam int MAX_N = 16;

  function automatic int state_w(input int n);
    return $clog2(n + 1);
  endfunction

  // Next state from S_k on input bit b: longest pattern prefix that is a suffix
  // of (first k pattern bits, then b). Pattern bit i (0 = first received) is
  // pattern[n-1-i].
  function automatic int kmp_next(input logic [MAX_N-1:0] pattern,
                                  input int n, input int k, input logic b);
    logic [MAX_N:0] seq;
    int             best;
    bit             ok;
    seq  = '0;
    best = 0;
    for (int i = 0; i < MAX_N; i++)
      if (i < k) seq[5'(i)] = pattern[4'(n - 1 - i)];
    seq[5'(k)] = b;
    for (int j = 1; j <= MAX_N; j++) begin
      if (j <= n && j <= k + 1) begin
        ok = 1'b1;
        for (int i = 0; i < MAX_N; i++)
          if (i < j && pattern[4'(n - 1 - i)] != seq[5'(k + 1 - j + i)]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset)                     r_count <= '0;
    else if (clr)                  r_count <= '0;
    else if (inc && r_count != '1) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/seq_detector_moore.sv
// Parametrised Moore serial pattern detector with input-valid qualifier,
// saturating match counter and a debug view of the state index.
module seq_detector_moore
  import seq_det_pkg::*;
#(
  parameter int           N       = 3,
  parameter logic [N-1:0] PATTERN = 3'b111,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8,
  localparam int          SW      = state_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             A,
  input  logic             en,
  input  logic             clr,
  output logic             Y,
  output logic [CNT_W-1:0] match_count,
  output logic [SW-1:0]    state_dbg
);

  localparam logic [MAX_N-1:0] PAT16 = MAX_N'(PATTERN);
  localparam logic [SW-1:0]    S_N   = SW'(N);

  logic [SW-1:0] w_next_tbl [N+1][2];
  logic [SW-1:0] w_next;
  logic          w_inc;
  logic [SW-1:0] r_state;

  // Non-overlapping mode leaves S_N as if from empty, so it reuses the S_0 row.
  for (genvar k = 0; k <= N; k++) begin : g_state
    for (genvar b = 0; b < 2; b++) begin : g_bit
      localparam int            KSRC = (k == N && !OVERLAP) ? 0 : k;
      localparam logic [SW-1:0] NXT  = SW'(kmp_next(PAT16, N, KSRC, 1'(b)));
      assign w_next_tbl[k][b] = NXT;
    end
  end

  assign w_next = w_next_tbl[r_state][A];
  assign w_inc  = en && (w_next == S_N);

  always_ff @(posedge clk) begin
    if (reset)   r_state <= '0;
    else if (en) r_state <= w_next;
  end

  // Moore output: decoded from the state register only, never from A.
  assign Y         = (r_state == S_N);
  assign state_dbg = r_state;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc),
    .clr   (clr),
    .count (match_count)
  );

endmodule
